inst_fetch_queue: RTL and testbench

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/inst_fetch_queue_if.sv | 24 ++
 rtl/inst_fetch_queue.sv | 186 ++++++++++++++++++
 tb/tb_inst_fetch_queue.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bundle: control inputs, instruction-memory bus and decode-side queue head.
interface inst_fetch_queue_if;
    logic        start_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;

    modport master (
        input  start_i, redirect_i, redirect_pc_i, imem_ack_i, imem_rdata_i, inst_ready_i,
        output imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o
    );

    modport slave (
        output start_i, redirect_i, redirect_pc_i, imem_ack_i, imem_rdata_i, inst_ready_i,
        input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch unit: single-outstanding memory request FSM feeding a DEPTH-entry queue,
// with redirect flush and discard of a request in flight at redirect time.
module inst_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    inst_fetch_queue_if.master bus
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_addr;
    logic            r_req;
    entry_t          r_mem [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            r_valid;
    entry_t          r_head;

    logic            w_flush;
    logic            w_ack;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_occ;
    logic            w_issue_ok;
    logic            w_new_req;
    logic            w_req_nxt;
    logic [31:0]     w_fetch_pc_nxt;
    logic [31:0]     w_addr_nxt;
    logic [PW-1:0]   w_wptr_nxt;
    logic [PW-1:0]   w_rptr_nxt;
    logic [CW-1:0]   w_count_nxt;
    entry_t          w_push_entry;
    entry_t          w_head_nxt;

    // Redirect wins over push and pop; issue reserves a slot against post-update occupancy.
    assign w_flush      = bus.redirect_i;
    assign w_ack        = bus.imem_ack_i;
    assign w_push       = (r_state == S_REQ) && w_ack && !w_flush;
    assign w_pop        = r_valid && bus.inst_ready_i && !w_flush;
    assign w_occ        = r_count + CW'(w_push) - CW'(w_pop);
    assign w_issue_ok   = bus.start_i && !w_flush && (w_occ < CW'(DEPTH));
    assign w_push_entry = '{pc: r_fetch_pc, inst: bus.imem_rdata_i};

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_issue_ok) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (w_flush) begin
                    w_state_nxt = w_ack ? S_IDLE : S_DRAIN;
                end else if (w_ack) begin
                    w_state_nxt = w_issue_ok ? S_REQ : S_IDLE;
                end
            end
            S_DRAIN: begin
                // The discarded request must complete before anything new issues.
                if (w_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath-control logic
    always_comb begin
        w_fetch_pc_nxt = r_fetch_pc;
        w_addr_nxt     = r_addr;
        w_new_req      = 1'b0;
        w_req_nxt      = (w_state_nxt != S_IDLE);

        if (w_flush) begin
            w_fetch_pc_nxt = {bus.redirect_pc_i[31:2], 2'b00};
        end else if (w_push) begin
            w_fetch_pc_nxt = r_fetch_pc + 32'd4;
        end

        if (w_issue_ok && ((r_state == S_IDLE) || w_push)) begin
            w_new_req  = 1'b1;
            w_addr_nxt = w_fetch_pc_nxt;
        end
    end

    // Queue pointer / head computation
    always_comb begin
        w_wptr_nxt  = r_wptr;
        w_rptr_nxt  = r_rptr;
        w_count_nxt = w_occ;
        if (w_flush) begin
            w_wptr_nxt  = '0;
            w_rptr_nxt  = '0;
            w_count_nxt = '0;
        end else begin
            if (w_push) begin
                w_wptr_nxt = r_wptr + PW'(1);
            end
            if (w_pop) begin
                w_rptr_nxt = r_rptr + PW'(1);
            end
        end
        // Bypass so a push into an empty slot is visible at the head next cycle.
        if (w_push && (w_rptr_nxt == r_wptr)) begin
            w_head_nxt = w_push_entry;
        end else begin
            w_head_nxt = r_mem[w_rptr_nxt];
        end
    end

    // Fetch address and request strobe
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_fetch_pc <= RESET_PC;
            r_addr     <= '0;
            r_req      <= 1'b0;
        end else begin
            r_fetch_pc <= w_fetch_pc_nxt;
            r_req      <= w_req_nxt;
            if (w_new_req) begin
                r_addr <= w_addr_nxt;
            end
        end
    end

    // Queue storage, pointers and registered head
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_head  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_push_entry;
            end
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
            r_head  <= w_head_nxt;
        end
    end

    assign bus.imem_req_o   = r_req;
    assign bus.imem_addr_o  = r_addr;
    assign bus.inst_valid_o = r_valid;
    assign bus.inst_o       = r_head.inst;
    assign bus.inst_pc_o    = r_head.pc;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized bench for inst_fetch_queue against a transaction-level queue model.
module tb_inst_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          N_CYC    = 1500;
    localparam int          RST_CYC  = 700;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    inst_fetch_queue_if bus ();

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Model: one request in flight (optionally to be discarded) plus an ordered queue.
    bit          m_busy;
    bit          m_drain;
    logic [31:0] m_addr;
    logic [31:0] m_pc;
    logic [63:0] q[$];

    task automatic model_reset();
        m_busy  = 1'b0;
        m_drain = 1'b0;
        m_addr  = '0;
        m_pc    = RESET_PC;
        q.delete();
    endtask

    task automatic model_step(input bit s, input bit rd, input logic [31:0] rpc,
                              input bit ack, input bit rdy, input logic [31:0] rdata);
        bit push;
        bit pop;
        if (rd) begin
            q.delete();
            m_pc = {rpc[31:2], 2'b00};
            if (m_busy && !ack) begin
                m_drain = 1'b1;
            end else begin
                m_busy  = 1'b0;
                m_drain = 1'b0;
            end
        end else begin
            pop  = (q.size() != 0) && rdy;
            push = m_busy && !m_drain && ack;
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back({m_addr, rdata});
                m_pc = m_pc + 32'd4;
            end
            if (m_busy && m_drain) begin
                if (ack) begin
                    m_busy  = 1'b0;
                    m_drain = 1'b0;
                end
            end else if (!m_busy || push) begin
                if (s && q.size() < int'(DEPTH)) begin
                    m_busy = 1'b1;
                    m_addr = m_pc;
                end else begin
                    m_busy = 1'b0;
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("imem_req", 32'(bus.imem_req_o), 32'(m_busy));
        if (m_busy) check("imem_addr", bus.imem_addr_o, m_addr);
        check("inst_valid", 32'(bus.inst_valid_o), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("inst", bus.inst_o, q[0][31:0]);
            check("inst_pc", bus.inst_pc_o, q[0][63:32]);
        end
    endtask

    task automatic check_reset_zero();
        check("rst_req", 32'(bus.imem_req_o), 32'd0);
        check("rst_addr", bus.imem_addr_o, 32'd0);
        check("rst_valid", 32'(bus.inst_valid_o), 32'd0);
        check("rst_inst", bus.inst_o, 32'd0);
        check("rst_pc", bus.inst_pc_o, 32'd0);
    endtask

    // Phases: zero-wait streaming, back-pressure fill/drain, then fully random traffic.
    task automatic drive_and_step(input int c);
        bit          s, rd, ack, rdy;
        logic [31:0] rpc, rdata;
        rpc = 32'($urandom_range(0, 16'hFFFF));
        if (c < 60) begin
            s = 1'b1; rd = 1'b0; rdy = 1'b1; ack = m_busy;
            rdata = m_addr ^ 32'hA5A5_A5A5;
        end else if (c < 100) begin
            s = 1'b1; rd = 1'b0; rdy = (c >= 80); ack = m_busy;
            rdata = m_addr ^ 32'hA5A5_A5A5;
        end else begin
            s     = ($urandom_range(0, 7) != 0);
            rd    = ($urandom_range(0, 15) == 0);
            ack   = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
            rdy   = ($urandom_range(0, 2) != 0);
            rdata = $urandom;
        end
        bus.start_i       = s;
        bus.redirect_i    = rd;
        bus.redirect_pc_i = rpc;
        bus.imem_ack_i    = ack;
        bus.inst_ready_i  = rdy;
        bus.imem_rdata_i  = rdata;
        model_step(s, rd, rpc, ack, rdy, rdata);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_reset_zero();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.start_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.imem_ack_i    = 1'b0;
        bus.imem_rdata_i  = '0;
        bus.inst_ready_i  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_zero();
        rst_n = 1'b1;
        drive_and_step(0);
        for (int c = 1; c < N_CYC; c++) begin
            @(posedge clk);
            #1;
            check_outputs();
            if (c == RST_CYC) do_reset();
            drive_and_step(c);
        end
        @(posedge clk);
        #1;
        check_outputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
